// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation controller.
package puf_pkg;

    localparam int unsigned DEF_N         = 128;
    localparam int unsigned DEF_RESP_BITS = 32;
    localparam int unsigned DEF_SETTLE    = 8;
    localparam int unsigned DEF_VOTES     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } puf_state_t;

    // Right-shifting Galois masks, right-aligned: term x^e maps to bit e-1.
    function automatic logic [127:0] lfsr_taps(input int unsigned n);
        case (n)
            128:     return {8'hE1, 120'h0};
            64:      return {64'h0, 64'hD800_0000_0000_0000};
            32:      return {96'h0, 32'h8020_0003};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side request/response handshake of the PUF evaluation controller.
interface puf_eval_ctrl_if #(
    parameter int unsigned N         = 128,
    parameter int unsigned RESP_BITS = 32
);
    logic                 start_valid;
    logic                 start_ready;
    logic [N-1:0]         seed;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] resp_data;
    logic                 busy;

    modport master (
        output start_valid, seed, resp_ready,
        input  start_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  start_valid, seed, resp_ready,
        output start_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for the asynchronous arbiter latch output.
module puf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: LFSR-expanded challenges, race launch, synchronized sampling.
// Optional PUF_MAJORITY_VOTE_EN: evaluate each bit VOTES times and take the majority.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned RESP_BITS = DEF_RESP_BITS,
    parameter int unsigned SETTLE    = DEF_SETTLE,
    parameter int unsigned VOTES     = DEF_VOTES
) (
    input  logic                clk,
    input  logic                rst,
    puf_eval_ctrl_if.slave      host,
    output logic [N-1:0]        challenge,
    output logic                race0,
    output logic                race1,
    input  logic                puf_out
);

    localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));
    localparam int unsigned  CW   = $clog2(SETTLE + 2);
    localparam int unsigned  KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    if (!(N == 128 || N == 64 || N == 32) || RESP_BITS < 1 || RESP_BITS > 64 ||
        SETTLE < 2 || VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_cfg
        $error("puf_eval_ctrl: unsupported parameter combination");
    end

    puf_state_t     state;
    logic           race;
    logic [CW-1:0]  cnt;
    logic [KW-1:0]  k;
    logic           sampled;
    logic           bit_done;
    logic           bit_val;

    puf_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (puf_out),
        .q   (sampled)
    );

    // Both race inputs come from one flop so the edges launch together.
    assign race0 = race;
    assign race1 = race;

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] c);
        return (c >> 1) ^ (c[0] ? TAPS : '0);
    endfunction

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned VW = $clog2(VOTES + 1);
    localparam int unsigned EW = (VOTES > 1) ? $clog2(VOTES) : 1;

    logic [VW-1:0] votes;
    logic [VW-1:0] votes_nxt;
    logic [EW-1:0] ev;

    always_comb begin
        votes_nxt = votes + VW'(sampled);
        bit_done  = (ev == EW'(VOTES - 1));
        bit_val   = (votes_nxt > VW'(VOTES / 2));
    end
`else
    always_comb begin
        bit_done = 1'b1;
        bit_val  = sampled;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            challenge        <= '0;
            race             <= 1'b0;
            cnt              <= '0;
            k                <= '0;
            host.start_ready <= 1'b0;
            host.resp_valid  <= 1'b0;
            host.resp_data   <= '0;
            host.busy        <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            votes            <= '0;
            ev               <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    host.start_ready <= 1'b1;
                    if (host.start_valid && host.start_ready) begin
                        challenge        <= (host.seed == '0) ? '1 : host.seed;
                        host.resp_data   <= '0;
                        host.start_ready <= 1'b0;
                        host.busy        <= 1'b1;
                        k                <= '0;
                        cnt              <= CW'(SETTLE - 1);
`ifdef PUF_MAJORITY_VOTE_EN
                        votes            <= '0;
                        ev               <= '0;
`endif
                        state            <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt == '0) begin
                        race  <= 1'b1;
                        state <= ST_FIRE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIRE: begin
                    cnt   <= CW'(SETTLE + 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_SAMPLE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    race  <= 1'b0;
                    cnt   <= CW'(SETTLE - 1);
                    state <= ST_LOAD;
`ifdef PUF_MAJORITY_VOTE_EN
                    votes <= bit_done ? '0 : votes_nxt;
                    ev    <= bit_done ? '0 : ev + 1'b1;
`endif
                    // Challenge only moves here, in the same edge that drops the race lines.
                    if (bit_done) begin
                        host.resp_data[k] <= bit_val;
                        challenge         <= lfsr_step(challenge);
                        k                 <= k + 1'b1;
                        if (k == KW'(RESP_BITS - 1)) begin
                            host.resp_valid <= 1'b1;
                            host.busy       <= 1'b0;
                            state           <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (host.resp_ready) begin
                        host.resp_valid  <= 1'b0;
                        host.start_ready <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed self-checking bench for puf_eval_ctrl with a behavioural arbiter model.
// Build with PUF_MAJORITY_VOTE_EN to exercise majority voting (model flips 2 of 5 evaluations).
module tb_puf_eval_ctrl;

    localparam int unsigned N        = 128;
    localparam int unsigned RB       = 32;
    localparam int unsigned SETTLE   = 8;
    localparam int unsigned VOTES    = 5;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned E        = VOTES;
`else
    localparam int unsigned E        = 1;
`endif
    localparam int unsigned EVAL_CYC = 2 * SETTLE + 4;
    localparam int unsigned LAT      = RB * E * EVAL_CYC + 1;
    localparam logic [N-1:0] TB_TAPS = {8'hE1, 120'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  challenge;
    logic          race0, race1;
    logic          puf_out = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;
    int cyc      = 0;

    puf_eval_ctrl_if #(.N(N), .RESP_BITS(RB)) bus();

    puf_eval_ctrl #(
        .N         (N),
        .RESP_BITS (RB),
        .SETTLE    (SETTLE),
        .VOTES     (VOTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .challenge (challenge),
        .race0     (race0),
        .race1     (race1),
        .puf_out   (puf_out)
    );

    always #5 clk = ~clk;

    // Arbiter model: XOR of challenge[7:0], valid 3 cycles after race rises, cleared when race drops.
    int   rcnt = 0;
    int   ev   = 0;
    logic rd   = 1'b0;
    logic flip;
`ifdef PUF_MAJORITY_VOTE_EN
    assign flip = (ev == 1) || (ev == 3);
`else
    assign flip = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            rcnt    <= 0;
            ev      <= 0;
            rd      <= 1'b0;
            puf_out <= 1'b0;
        end else begin
            rd <= race0;
            if (rd && !race0) ev <= (ev == int'(E) - 1) ? 0 : ev + 1;
            if (!race0) begin
                rcnt    <= 0;
                puf_out <= 1'b0;
            end else begin
                if (rcnt != 3) rcnt <= rcnt + 1;
                if (rcnt == 2) puf_out <= (^challenge[7:0]) ^ flip;
            end
        end
    end

    logic         prev_race = 1'b0;
    logic [N-1:0] prev_chal = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (race0 !== race1) viol <= viol + 1;
            if (race0 && prev_race && challenge !== prev_chal) viol <= viol + 1;
        end
        prev_race <= race0;
        prev_chal <= challenge;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] step(input logic [N-1:0] c);
        return (c >> 1) ^ (c[0] ? TB_TAPS : '0);
    endfunction

    function automatic logic [RB-1:0] golden(input logic [N-1:0] s);
        logic [N-1:0]  c;
        logic [RB-1:0] r;
        c = (s == '0) ? '1 : s;
        r = '0;
        for (int i = 0; i < int'(RB); i++) begin
            r[i] = ^c[7:0];
            c    = step(c);
        end
        return r;
    endfunction

    // Leaves the bench at the first negedge after the start handshake edge (cyc = 1).
    task automatic do_start(input logic [N-1:0] s, input string tag);
        int w;
        w = 0;
        bus.start_valid = 1'b1;
        bus.seed        = s;
        while (bus.start_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start_ready"}, bus.start_ready, 1);
        @(negedge clk);
        bus.start_valid = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_ready_low"}, bus.start_ready, 0);
    endtask

    task automatic wait_resp(input logic [RB-1:0] exp, input string tag);
        while (bus.resp_valid !== 1'b1 && cyc < int'(LAT) + 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_resp"}, bus.resp_data, exp);
    endtask

    task automatic accept();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("accept_valid_low", bus.resp_valid, 0);
    endtask

    logic [N-1:0]  s2;
    logic [N-1:0]  s3;
    logic [RB-1:0] held;
    int            rises;
    int            bad_data, bad_race, bad_ready, bad_valid;
    logic          pr;

    initial begin
        s2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        s3 = {4{32'hDEAD_BEEF}};
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.seed        = '0;
        bus.resp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_challenge", challenge, 0);
        check("rst_race", {race0, race1}, 0);
        check("rst_valid", bus.resp_valid, 0);
        check("rst_data", bus.resp_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.start_ready, 0);
        rst = 1'b0;
        #1 check("rel_ready_same", bus.start_ready, 0);
        @(negedge clk);
        check("rel_ready_next", bus.start_ready, 1);

        // Seed 1: only bit 0 sees a nonzero low byte before the taps shift down.
        do_start(128'h1, "seed1");
        check("seed1_load", challenge, 128'h1);
        wait_resp(32'h0000_0001, "seed1");
        accept();

        // Seed 0 is replaced by all-ones; low byte stays 0xFF, so every bit is 0.
        do_start('0, "seed0");
        check("seed0_load", challenge, {N{1'b1}});
        while (cyc < int'(E * EVAL_CYC) + 1) begin
            @(negedge clk);
            cyc++;
        end
        check("seed0_step1", challenge, {8'h9E, {120{1'b1}}});
        wait_resp(32'h0000_0000, "seed0");
        accept();

        // Back-pressure with a competing start request.
        do_start(s2, "s2");
        wait_resp(golden(s2), "s2");
        held = bus.resp_data;
        bus.start_valid = 1'b1;
        bus.seed        = s3;
        bad_data = 0; bad_race = 0; bad_ready = 0; bad_valid = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.resp_data !== held) bad_data++;
            if (race0 !== 1'b0) bad_race++;
            if (bus.start_ready !== 1'b0) bad_ready++;
            if (bus.resp_valid !== 1'b1) bad_valid++;
        end
        check("bp_data_stable", bad_data, 0);
        check("bp_no_race", bad_race, 0);
        check("bp_start_blocked", bad_ready, 0);
        check("bp_valid_held", bad_valid, 0);
        accept();
        check("bp_ready_after_accept", bus.start_ready, 1);
        do_start(s3, "s3");
        wait_resp(golden(s3), "s3");
        accept();

        // Abort during WAIT of bit 10.
        do_start(s2, "abort");
        rises = 0;
        pr    = 1'b0;
        while (rises < 10 * int'(E) + 1 && cyc < int'(LAT)) begin
            @(negedge clk);
            cyc++;
            if (race0 && !pr) rises++;
            pr = race0;
        end
        check("abort_rises", rises, 10 * E + 1);
        repeat (3) @(negedge clk);
        check("abort_in_wait", race0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_challenge", challenge, 0);
        check("abort_race", {race0, race1}, 0);
        check("abort_valid", bus.resp_valid, 0);
        check("abort_data", bus.resp_data, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.start_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rel_ready", bus.start_ready, 1);
        do_start(s2, "after_abort");
        wait_resp(golden(s2), "after_abort");
        accept();

        check("race_monitor", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
